pc_sequencer: RTL

//  Parametrised program-counter sequencer for the MIPS fetch stage: holds the current PC,

---
 rtl/pc_pkg.sv | 20 ++
 rtl/pc_if.sv | 30 +++
 rtl/pc_ras.sv | 68 ++++++
 rtl/pc_sequencer.sv | 114 +++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared fetch-stage definitions: next-PC select encoding and alignment helper.
// Used by pc_sequencer and later fetch/branch-unit blocks.
package pc_pkg;

  localparam int unsigned PcMaskWidth = 64;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_SEQ,
    SEL_RAS,
    SEL_REDIR,
    SEL_EXC
  } pc_sel_e;

  // Mask that clears the low log2(step) bits; step must be a power of two.
  function automatic logic [PcMaskWidth-1:0] align_mask(input int unsigned step);
    return ~(PcMaskWidth'(step) - PcMaskWidth'(1));
  endfunction

endpackage

// File: rtl/pc_if.sv
// Fetch-side bundle between control/hazard logic, pc_sequencer and instruction memory.
// CallIn/RetIn/RasHit are only meaningful when PC_RAS_EN is defined.
interface pc_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             StallIn;
  logic             ExcValid;
  logic             RedirectValid;
  logic [WIDTH-1:0] RedirectTarget;
  logic             FetchReady;
  logic             CallIn;
  logic             RetIn;
  logic             FetchValid;
  logic [WIDTH-1:0] PcOut;
  logic [WIDTH-1:0] PcPlusStep;
  logic             AlignErr;
  logic             RasHit;

  modport master (
    input  StallIn, ExcValid, RedirectValid, RedirectTarget, FetchReady, CallIn, RetIn,
    output FetchValid, PcOut, PcPlusStep, AlignErr, RasHit
  );

  modport slave (
    output StallIn, ExcValid, RedirectValid, RedirectTarget, FetchReady, CallIn, RetIn,
    input  FetchValid, PcOut, PcPlusStep, AlignErr, RasHit
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// A simultaneous push and pop replaces the top entry in place.
module pc_ras #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  top_q, top_d, top_inc, top_dec;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_pop;
  logic             wr_en;
  logic [PtrW-1:0]  wr_idx;

  assign top_data = mem_q[top_q];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign top_inc  = PtrW'((32'(top_q) + 32'd1) % DEPTH);
  assign top_dec  = PtrW'((32'(top_q) + DEPTH - 32'd1) % DEPTH);

  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = top_q;
    if (push && do_pop) begin
      wr_en = 1'b1;
    end else if (push) begin
      wr_en   = 1'b1;
      wr_idx  = top_inc;
      top_d   = top_inc;
      count_d = full ? count_q : count_q + CntW'(1);
    end else if (do_pop) begin
      top_d   = top_dec;
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q   <= '0;
      count_q <= '0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// MIPS fetch-stage PC sequencer: priority next-PC mux, PC register and fetch handshake.
// Define PC_RAS_EN to add the return-address stack (pc_ras) and call/return prediction.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080),
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input logic  clk,
  input logic  rst,
  pc_if.master bus
);

  localparam logic [PcMaskWidth-1:0] AlignMaskFull = align_mask(STEP);
  localparam logic [WIDTH-1:0]       AlignMask     = AlignMaskFull[WIDTH-1:0];

  logic [WIDTH-1:0] pc_q, pc_d, pc_plus_step;
  logic             fetch_valid_q;
  logic             align_err_q, align_err_d;
  logic             ras_hit_q;
  logic             accept;
  logic             redirecting;
  logic             ras_pop, ras_push;
  logic [WIDTH-1:0] ras_top;
  pc_sel_e          sel;

  assign pc_plus_step = pc_q + WIDTH'(STEP);
  assign accept       = fetch_valid_q & bus.FetchReady & ~bus.StallIn;
  assign redirecting  = bus.ExcValid | bus.RedirectValid;

`ifdef PC_RAS_EN
  logic ras_empty;
  logic ras_full_unused;

  assign ras_pop  = accept & bus.RetIn & ~ras_empty & ~redirecting;
  assign ras_push = accept & bus.CallIn & ~redirecting;

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus_step),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full_unused)
  );
`else
  logic hint_unused;

  assign hint_unused = bus.CallIn ^ bus.RetIn;
  assign ras_pop     = 1'b0;
  assign ras_push    = 1'b0;
  assign ras_top     = '0;
`endif

  always_comb begin
    sel = SEL_HOLD;
    if (bus.ExcValid) begin
      sel = SEL_EXC;
    end else if (bus.RedirectValid) begin
      sel = SEL_REDIR;
    end else if (ras_pop) begin
      sel = SEL_RAS;
    end else if (accept) begin
      sel = SEL_SEQ;
    end
  end

  always_comb begin
    pc_d = pc_q;
    unique case (sel)
      SEL_EXC:   pc_d = EXC_VECTOR;
      SEL_REDIR: pc_d = bus.RedirectTarget & AlignMask;
      SEL_RAS:   pc_d = ras_top;
      SEL_SEQ:   pc_d = pc_plus_step;
      default:   pc_d = pc_q;
    endcase
  end

  // An exception takes the redirect's slot, so a misaligned target is not reported.
  assign align_err_d = ~bus.ExcValid & bus.RedirectValid & |(bus.RedirectTarget & ~AlignMask);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      align_err_q   <= 1'b0;
      ras_hit_q     <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      fetch_valid_q <= 1'b1;
      align_err_q   <= align_err_d;
      ras_hit_q     <= (sel == SEL_RAS);
    end
  end

  assign bus.FetchValid = fetch_valid_q;
  assign bus.PcOut      = pc_q;
  assign bus.PcPlusStep = pc_plus_step;
  assign bus.AlignErr   = align_err_q;
  assign bus.RasHit     = ras_hit_q;

  // ras_push only feeds the stack; keep it referenced in the default build too.
  logic push_unused;
  assign push_unused = ras_push;

endmodule
